// File: rtl/rt_align_generator.sv
// Residual generator: buffers Xin in a circular alignment FIFO and emits Rout = Xin - Cin
// when the matching IMF sample arrives. Define RT_SAT_EN to saturate instead of wrap.
module rt_align_generator #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 16,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    start,
    input  logic                    x_valid,
    input  logic signed [WIDTH-1:0] Xin,
    input  logic                    c_valid,
    input  logic signed [WIDTH-1:0] Cin,
    output logic                    r_valid,
    output logic signed [WIDTH-1:0] Rout,
    output logic                    follow_start,
    output logic                    ovf,
    output logic                    unf,
    output logic [LW-1:0]           level
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             r_rvalid;
    logic [WIDTH-1:0] r_rout;
    logic             r_fs;
    logic             r_ovf;
    logic             r_unf;

    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic [PW-1:0]    w_widx;
    logic [WIDTH-1:0] w_head;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;

    assign w_full  = (r_level == LW'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_pop   = !start && c_valid && !w_empty;
    // A flushing start always has room, so the sample lands in slot 0 of the new record.
    assign w_push  = x_valid && (start || !w_full || w_pop);
    assign w_widx  = start ? '0 : r_wptr;
    assign w_head  = r_mem[r_rptr];
    assign w_diff  = {w_head[WIDTH-1], w_head} - {Cin[WIDTH-1], Cin};

    always_comb begin
        w_res = w_diff[WIDTH-1:0];
`ifdef RT_SAT_EN
        if (w_diff[WIDTH] != w_diff[WIDTH-1]) begin
            w_res = w_diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[w_widx] <= Xin;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_rvalid <= 1'b0;
            r_rout   <= '0;
            r_fs     <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_fs <= start;
            if (start) begin
                r_wptr   <= w_push ? PW'(1) : '0;
                r_rptr   <= '0;
                r_level  <= LW'(w_push);
                r_rvalid <= 1'b0;
                r_ovf    <= 1'b0;
                r_unf    <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + PW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PW'(1);
                    r_rout <= w_res;
                end
                r_level  <= r_level + LW'(w_push) - LW'(w_pop);
                r_rvalid <= w_pop;
                if (x_valid && w_full && !w_pop) begin
                    r_ovf <= 1'b1;
                end
                if (c_valid && w_empty) begin
                    r_unf <= 1'b1;
                end
            end
        end
    end

    assign r_valid      = r_rvalid;
    assign Rout         = r_rout;
    assign follow_start = r_fs;
    assign ovf          = r_ovf;
    assign unf          = r_unf;
    assign level        = r_level;

endmodule

// File: tb/tb_rt_align_generator.sv
// Self-checking bench for rt_align_generator: queue-based reference model compared every
// cycle, plus literal expectations for the directed scenarios.
module tb_rt_align_generator;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic                    CLK = 1'b0;
    logic                    RST_N = 1'b0;
    logic                    start = 1'b0;
    logic                    x_valid = 1'b0;
    logic signed [WIDTH-1:0] Xin = '0;
    logic                    c_valid = 1'b0;
    logic signed [WIDTH-1:0] Cin = '0;
    logic                    r_valid;
    logic signed [WIDTH-1:0] Rout;
    logic                    follow_start;
    logic                    ovf;
    logic                    unf;
    logic [LW-1:0]           level;

    rt_align_generator #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .x_valid(x_valid), .Xin(Xin),
        .c_valid(c_valid), .Cin(Cin), .r_valid(r_valid), .Rout(Rout),
        .follow_start(follow_start), .ovf(ovf), .unf(unf), .level(level)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Reference model state
    int mq[$];
    int m_rv, m_rout, m_fs, m_ovf, m_unf, m_lvl;

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int reduce(int d);
`ifdef RT_SAT_EN
        if (d > 32767) return 32767;
        if (d < -32768) return -32768;
        return d;
`else
        int w;
        w = d & 32'h0000FFFF;
        if (w >= 32768) w -= 65536;
        return w;
`endif
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_rv = 0; m_rout = 0; m_fs = 0; m_ovf = 0; m_unf = 0; m_lvl = 0;
    endfunction

    function automatic void model_update();
        int sz;
        bit popok;
        sz = mq.size();
        m_fs = int'(start);
        if (start) begin
            mq.delete();
            m_ovf = 0; m_unf = 0; m_rv = 0;
            if (x_valid) mq.push_back(int'(Xin));
        end else begin
            popok = c_valid && (sz > 0);
            if (c_valid && sz == 0) m_unf = 1;
            if (x_valid && sz == DEPTH && !popok) m_ovf = 1;
            m_rv = int'(popok);
            if (popok) m_rout = reduce(mq.pop_front() - int'(Cin));
            if (x_valid && (sz < DEPTH || popok)) mq.push_back(int'(Xin));
        end
        m_lvl = mq.size();
    endfunction

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("r_valid", int'(r_valid), m_rv);
            chk("Rout", int'(Rout), m_rout);
            chk("follow_start", int'(follow_start), m_fs);
            chk("ovf", int'(ovf), m_ovf);
            chk("unf", int'(unf), m_unf);
            chk("level", int'(level), m_lvl);
        end
    end

    task automatic step();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic drive(bit s, bit xv, int xd, bit cv, int cd);
        start   = s;
        x_valid = xv;
        Xin     = WIDTH'(xd);
        c_valid = cv;
        Cin     = WIDTH'(cd);
    endtask

    initial begin
        int pushed;
        int guard;
        int exp_a;
        int exp_b;

        model_reset();
        #3;
        chk("reset_level", int'(level), 0);
        chk("reset_rvalid", int'(r_valid), 0);
        #9 RST_N = 1'b1;
        chk_en = 1'b1;

        // Basic residuals
        drive(0, 0, 0, 0, 0); step();
        drive(0, 1, 100, 0, 0); step();
        drive(0, 1, 200, 0, 0); step();
        drive(0, 1, 300, 0, 0); step();
        chk("t1_level3", int'(level), 3);
        drive(0, 0, 0, 1, 40); step();
        chk("t1_rv0", int'(r_valid), 1); chk("t1_r0", int'(Rout), 60);
        drive(0, 0, 0, 1, 50); step();
        chk("t1_rv1", int'(r_valid), 1); chk("t1_r1", int'(Rout), 150);
        drive(0, 0, 0, 1, 60); step();
        chk("t1_rv2", int'(r_valid), 1); chk("t1_r2", int'(Rout), 240);
        chk("t1_level0", int'(level), 0);
        drive(0, 0, 0, 0, 0); step();
        chk("t1_rv_idle", int'(r_valid), 0);

        // Fill, overflow, push+pop while full, drain
        drive(1, 0, 0, 0, 0); step();
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1, 1000 + i, 0, 0); step();
        end
        drive(0, 1, 9999, 0, 0); step();
        chk("t2_level_full", int'(level), 16);
        chk("t2_ovf", int'(ovf), 1);
        drive(0, 1, 5555, 1, 0); step();
        chk("t2_level_keep", int'(level), 16);
        chk("t2_ovf_keep", int'(ovf), 1);
        chk("t2_first_r", int'(Rout), 1000);
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 0, 1, 0); step();
        end
        chk("t2_last_r", int'(Rout), 5555);
        chk("t2_level_empty", int'(level), 0);

        // Underflow, then start flush with a sample
        drive(0, 0, 0, 1, 3); step();
        chk("t3_unf", int'(unf), 1);
        chk("t3_no_rv", int'(r_valid), 0);
        drive(1, 1, 7, 1, 2); step();
        chk("t3_unf_clr", int'(unf), 0);
        chk("t3_ovf_clr", int'(ovf), 0);
        chk("t3_level1", int'(level), 1);
        chk("t3_fs", int'(follow_start), 1);
        drive(0, 0, 0, 1, 2); step();
        chk("t3_fs_low", int'(follow_start), 0);
        chk("t3_r", int'(Rout), 5);

        // Push and pop together while empty: underflow, push accepted
        drive(0, 1, 42, 1, 1); step();
        chk("t3b_unf", int'(unf), 1);
        chk("t3b_level", int'(level), 1);
        chk("t3b_no_rv", int'(r_valid), 0);

        // Limits
`ifdef RT_SAT_EN
        exp_a = 32767; exp_b = -32768;
`else
        exp_a = -32768; exp_b = 32767;
`endif
        drive(1, 0, 0, 0, 0); step();
        drive(0, 1, 32767, 0, 0); step();
        drive(0, 1, -32768, 1, -1); step();
        chk("t4_pos_limit", int'(Rout), exp_a);
        drive(0, 0, 0, 1, 1); step();
        chk("t4_neg_limit", int'(Rout), exp_b);

        // Random streaming with the IMF lagging the input
        drive(1, 0, 0, 0, 0); step();
        pushed = 0;
        guard  = 0;
        while ((pushed < 1000 || mq.size() > 0) && guard < 5000) begin
            bit xv;
            bit cv;
            guard++;
            xv = (pushed < 1000) && ($urandom_range(0, 3) != 0);
            cv = (mq.size() > 0) && (mq.size() >= 12 || $urandom_range(0, 1) == 1);
            drive(0, xv, int'($urandom_range(0, 65535)), cv, int'($urandom_range(0, 65535)));
            if (xv) pushed++;
            step();
        end
        chk("t5_terminated", int'(guard < 5000), 1);
        chk("t5_ovf", int'(ovf), 0);
        chk("t5_unf", int'(unf), 0);

        // Asynchronous reset mid-stream with level 5
        drive(1, 0, 0, 0, 0); step();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 10 * (i + 1), 0, 0); step();
        end
        drive(0, 1, 60, 1, 4); step();
        chk("t6_level5", int'(level), 5);
        chk("t6_rv_pre", int'(r_valid), 1);
        drive(0, 0, 0, 0, 0);
        #2;
        chk_en = 1'b0;
        RST_N  = 1'b0;
        #1;
        chk("t6_rst_rv", int'(r_valid), 0);
        chk("t6_rst_rout", int'(Rout), 0);
        chk("t6_rst_level", int'(level), 0);
        chk("t6_rst_ovf", int'(ovf), 0);
        chk("t6_rst_unf", int'(unf), 0);
        chk("t6_rst_fs", int'(follow_start), 0);
        model_reset();
        #3 RST_N = 1'b1;
        chk_en = 1'b1;
        drive(0, 1, 111, 0, 0); step();
        drive(0, 0, 0, 1, 11); step();
        chk("t6_after_rv", int'(r_valid), 1);
        chk("t6_after_r", int'(Rout), 100);
        drive(0, 0, 0, 0, 0); step();
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
